instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning encoded-word FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning instruction-memory byte-address width.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit, one-cycle pulse that begins a load session.
REQ-006 SHALL have port base_addr, input, ADDR_W bits, first write address, sampled on start.
REQ-007 SHALL have port in_valid, input, 1 bit; and in_ready, output, 1 bit: the field handshake.
REQ-008 SHALL have port in_op, input, 2 bits; in_funct, input, 6 bits; in_rd, input, 5 bits; in_rn, input, 5 bits; in_src2, input, 14 bits (immediate, or Rm in [4:0]); in_offset, input, 30 bits (branch word offset).
REQ-009 SHALL have port in_last, input, 1 bit, marking the final instruction of the session.
REQ-010 SHALL have port imem_we, output, 1 bit; imem_addr, output, ADDR_W bits; imem_wdata, output, 32 bits; imem_ready, input, 1 bit.
REQ-011 SHALL have port busy, output, 1 bit; done, output, 1 bit (one-cycle pulse); err_illegal, output, 1 bit (one-cycle pulse); err_count, output, 8 bits.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN, DRAIN and DONE.
REQ-013 SHALL move from IDLE to RUN on start, loading the write pointer with base_addr; start SHALL be ignored in every other state.
REQ-014 SHALL drive in_ready = (state==RUN) && (fifo_count < DEPTH), with no look-ahead on simultaneous pop.
REQ-015 SHALL accept a field set only on a cycle where in_valid && in_ready.
REQ-016 SHALL encode Op 00 and Op 01 as {op, funct, rd, rn, src2}, bit ranges [31:30], [29:24], [23:19], [18:14] and [13:0].
REQ-017 SHALL encode Op 10 as {2'b10, offset[29:0]}.
REQ-018 SHALL treat the following as illegal: Op 11; and Op 00 with funct[4:1] outside {0100, 0010, 0000, 1100, 1101, 1010}.
REQ-019 SHALL, for an illegal field set, not enqueue it, pulse err_illegal in the cycle after acceptance, and increment err_count, saturating at 255.
REQ-020 SHALL register a legal accepted word into the FIFO, visible at the FIFO head the next cycle.
REQ-021 SHALL assert imem_we when the FIFO is non-empty and imem_ready is high, driving the head word on imem_wdata and the pointer on imem_addr.
REQ-022 SHALL pop the FIFO and advance the pointer by 4, modulo 2^ADDR_W (wrap-around, no error), on every cycle where imem_we is high.
REQ-023 SHALL give a minimum latency of 1 cycle from acceptance to imem_we.
REQ-024 SHALL sustain one write per cycle while imem_ready is held high.
REQ-025 SHALL, when imem_ready is low, hold imem_we low and keep the FIFO and pointer unchanged.
REQ-026 SHALL allow push and pop in the same cycle, leaving the count unchanged.
REQ-027 SHALL move RUN to DRAIN on acceptance of in_last, including when that instruction is illegal; in_ready SHALL be low in DRAIN.
REQ-028 SHALL move DRAIN to DONE when the FIFO is empty and no write is in progress.
REQ-029 SHALL pulse done for one cycle in DONE and return to IDLE the next cycle.
REQ-030 SHALL drive busy high in RUN and DRAIN only.
REQ-031 SHALL hold err_count across sessions and clear it only on reset.

Reset
REQ-032 SHALL, on reset, set state to IDLE, empty the FIFO, and zero the pointer.
REQ-033 SHALL, on reset, drive imem_we, in_ready, busy, done and err_illegal to 0, imem_addr and imem_wdata to 0, and err_count to 0.
REQ-034 SHALL, on reset asserted mid-session, abandon pending FIFO words unwritten; words already written stay in memory.
REQ-035 SHALL ignore start in the same cycle as reset.

Verification
REQ-036 SHALL cover: start with base_addr=0x100; single ADD (op 00, funct 001000, rd 1, rn 2, src2 3) with in_last, imem_ready=1 -> imem_we at next cycle, addr 0x100, wdata 0x0808_8003, done two cycles later.
REQ-037 SHALL cover: branch op 10 with offset 0x3FFF_FFFE -> wdata 0xBFFF_FFFE.
REQ-038 SHALL cover: imem_ready=0 while 5 legal instructions are offered -> in_ready drops after 4 acceptances; releasing imem_ready -> writes at +0, +4, +8, +12, +16 in order.
REQ-039 SHALL cover: op 11, then op 00 funct[4:1]=0111 -> two err_illegal pulses, err_count=2, no imem_we; a following legal word is written at base_addr.
REQ-040 SHALL cover: base_addr=0x3FC, 2 instructions -> addresses 0x3FC then 0x000.
REQ-041 SHALL cover: reset asserted in DRAIN with 3 words queued -> next cycle IDLE, imem_we=0, busy=0, err_count=0, no done pulse.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs instruction field sets into 32-bit words and streams them
//            into an instruction memory through a small FIFO, one write per
//            cycle. A session starts at base_addr and ends after the word
//            flagged in_last. Illegal field sets are dropped and counted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   start, base_addr   : session start pulse and first write address
//   in_valid/in_ready  : field-set handshake
//   in_op, in_funct,
//   in_rd, in_rn,
//   in_src2, in_offset : instruction fields
//   in_last            : final instruction of the session
//   imem_we/addr/wdata : instruction-memory write port
//   imem_ready         : memory can take a write this cycle
//   busy               : high while a session is in RUN or DRAIN
//   done               : one-cycle pulse at the end of a session
//   err_illegal        : one-cycle pulse after an illegal field set
//   err_count          : saturating illegal count, cleared only by reset
// ============================================================================
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [13:0]       in_src2,
  input  logic [29:0]       in_offset,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [7:0]        err_count
);

  // DEPTH is a power of two, so the FIFO pointers wrap by natural overflow.
  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam int                 c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic               err_illegal_q;
  logic [7:0]         err_count_q;

  logic [31:0]        fifo_mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q;
  logic [c_ptr_w-1:0] rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic        w_fifo_empty;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  always_comb begin
    w_fifo_empty = (count_q == '0);
    // No look-ahead: a full FIFO refuses input even if it pops this cycle.
    w_in_ready   = (state_q == RUN) && (count_q < c_full);
    w_accept     = in_valid && w_in_ready;
    w_push       = w_accept && w_legal;
    w_pop        = !w_fifo_empty && imem_ready;
  end

  // Op 00 only allows a subset of function groups (funct[4:1]); op 11 is
  // reserved. Ops 01 and 10 are always legal.
  always_comb begin
    w_legal = 1'b1;
    case (in_op)
      2'b00: begin
        case (in_funct[4:1])
          4'b0100, 4'b0010, 4'b0000,
          4'b1100, 4'b1101, 4'b1010: w_legal = 1'b1;
          default:                   w_legal = 1'b0;
        endcase
      end
      2'b11:   w_legal = 1'b0;
      default: w_legal = 1'b1;
    endcase
  end

  // Branches carry a 30-bit word offset; everything else uses the R/I layout.
  always_comb begin
    if (in_op == 2'b10) begin
      w_word = {2'b10, in_offset};
    end else begin
      w_word = {in_op, in_funct, in_rd, in_rn, in_src2};
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // The pointer is loaded only in IDLE, where the FIFO is always empty, so a
  // load and an advance never compete.
  always_comb begin
    addr_d = addr_q;
    if ((state_q == IDLE) && start) begin
      addr_d = base_addr;
    end else if (w_pop) begin
      addr_d = addr_q + ADDR_W'(4);
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; occupancy tracks validity)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      fifo_mem_q[wr_ptr_q] <= w_word;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      addr_q        <= '0;
      err_illegal_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
      end
      count_q       <= count_d;
      addr_q        <= addr_d;
      err_illegal_q <= w_accept && !w_legal;
      if (w_accept && !w_legal && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Session state machine with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // An illegal last instruction still closes the session.
          if (w_accept && in_last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Empty implies no write can be in flight this cycle.
          if (w_fifo_empty) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready    = w_in_ready;
  assign imem_we     = w_pop;
  assign imem_addr   = addr_q;
  // Gate the head so the write data reads zero whenever nothing is queued.
  assign imem_wdata  = w_fifo_empty ? 32'h0 : fifo_mem_q[rd_ptr_q];
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_illegal = err_illegal_q;
  assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed testbench for instr_encoder with hand-computed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [5:0]        in_funct;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [13:0]       in_src2;
  logic [29:0]       in_offset;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic [7:0]        err_count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_funct   (in_funct),
    .in_rd      (in_rd),
    .in_rn      (in_rn),
    .in_src2    (in_src2),
    .in_offset  (in_offset),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .imem_ready (imem_ready),
    .busy       (busy),
    .done       (done),
    .err_illegal(err_illegal),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Directed instruction table with hand-encoded words.
  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [13:0] src2;
    logic [29:0] off;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [5];

  int n_checks = 0;
  int n_pass   = 0;

  // Observed memory writes and pulses, sampled mid-cycle.
  logic [ADDR_W-1:0] wa [$];
  logic [31:0]       wd [$];
  int                done_seen = 0;
  int                err_seen  = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
    if (done)        done_seen++;
    if (err_illegal) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leaves time at posedge+2: inputs may be driven, outputs sampled after #1.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_session(input logic [ADDR_W-1:0] addr);
    start     = 1'b1;
    base_addr = addr;
    step();
    start     = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                       input logic [4:0] rd, input logic [4:0] rn,
                       input logic [13:0] src2, input logic [29:0] off,
                       input logic last);
    in_op     = op;
    in_funct  = funct;
    in_rd     = rd;
    in_rn     = rn;
    in_src2   = src2;
    in_offset = off;
    in_last   = last;
    in_valid  = 1'b1;
  endtask

  // Called one unit after drive; returns at posedge+2 after the accepting edge.
  task automatic wait_accept(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    if (!in_ready) check(tag, 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [5:0] funct,
                      input logic [4:0] rd, input logic [4:0] rn,
                      input logic [13:0] src2, input logic [29:0] off,
                      input logic last);
    drive(op, funct, rd, rn, src2, off, last);
    #1;
    wait_accept("accept_timeout");
  endtask

  task automatic send_idx(input int i, input logic last);
    send(tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].rn, tbl[i].src2, tbl[i].off, last);
  endtask

  // Returns at posedge+2 after the cycle in which done was seen.
  task automatic wait_done(input string tag);
    int n = 0;
    #1;
    while (!done && n < 100) begin
      step();
      #1;
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b00, 6'b000100, 5'd3,  5'd4,  14'h0010, 30'd0, 32'h0419_0010};
    tbl[1] = '{2'b01, 6'b111111, 5'd31, 5'd31, 14'h3FFF, 30'd0, 32'h7FFF_FFFF};
    tbl[2] = '{2'b10, 6'b000000, 5'd0,  5'd0,  14'h0000, 30'd5, 32'h8000_0005};
    tbl[3] = '{2'b00, 6'b011010, 5'd0,  5'd0,  14'h0000, 30'd0, 32'h1A00_0000};
    tbl[4] = '{2'b01, 6'b000001, 5'd1,  5'd1,  14'h0001, 30'd0, 32'h4108_4001};

    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_funct   = '0;
    in_rd      = '0;
    in_rn      = '0;
    in_src2    = '0;
    in_offset  = '0;
    in_last    = 1'b0;
    imem_ready = 1'b1;
    step();
    step();
    #1;
    check("rst_in_ready",   {31'd0, in_ready},    32'd0);
    check("rst_imem_we",    {31'd0, imem_we},     32'd0);
    check("rst_busy",       {31'd0, busy},        32'd0);
    check("rst_done",       {31'd0, done},        32'd0);
    check("rst_err_ill",    {31'd0, err_illegal}, 32'd0);
    check("rst_addr",       {22'd0, imem_addr},   32'd0);
    check("rst_wdata",      imem_wdata,           32'd0);
    check("rst_err_count",  {24'd0, err_count},   32'd0);
    reset = 1'b0;
    step();

    // Single ADD: write one cycle after acceptance, done two cycles later.
    start_session(10'h100);
    #1;
    check("t1_busy",     {31'd0, busy},     32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    send(2'b00, 6'b001000, 5'd1, 5'd2, 14'd3, 30'd0, 1'b1);
    #1;
    check("t1_we",       {31'd0, imem_we},   32'd1);
    check("t1_addr",     {22'd0, imem_addr}, 32'h100);
    check("t1_wdata",    imem_wdata,         32'h0808_8003);
    check("t1_drain_rdy",{31'd0, in_ready},  32'd0);
    step();
    #1;
    check("t1_we_off",   {31'd0, imem_we},   32'd0);
    check("t1_done_early",{31'd0, done},     32'd0);
    step();
    #1;
    check("t1_done",     {31'd0, done},      32'd1);
    check("t1_busy_done",{31'd0, busy},      32'd0);
    step();
    #1;
    check("t1_done_1cyc",{31'd0, done},      32'd0);
    step();

    // Branch with large offset.
    start_session(10'h200);
    send(2'b10, 6'd0, 5'd0, 5'd0, 14'd0, 30'h3FFF_FFFE, 1'b1);
    #1;
    check("t2_we",    {31'd0, imem_we},   32'd1);
    check("t2_addr",  {22'd0, imem_addr}, 32'h200);
    check("t2_wdata", imem_wdata,         32'hBFFF_FFFE);
    step();
    wait_done("t2_done");

    // Back-pressure: FIFO fills at four, then drains in order.
    imem_ready = 1'b0;
    wa.delete();
    wd.delete();
    start_session(10'h040);
    for (int i = 0; i < 4; i++) send_idx(i, 1'b0);
    drive(tbl[4].op, tbl[4].funct, tbl[4].rd, tbl[4].rn, tbl[4].src2, tbl[4].off, 1'b1);
    #1;
    check("t3_full_rdy",  {31'd0, in_ready}, 32'd0);
    check("t3_held_we",   {31'd0, imem_we},  32'd0);
    step();
    #1;
    check("t3_full_rdy2", {31'd0, in_ready}, 32'd0);
    imem_ready = 1'b1;
    wait_accept("t3_accept5");
    wait_done("t3_done");
    check("t3_nwrites", wa.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wa.size()) begin
        check($sformatf("t3_addr%0d", i), {22'd0, wa[i]}, 32'h040 + 32'(4 * i));
        check($sformatf("t3_data%0d", i), wd[i], tbl[i].word);
      end
    end

    // Illegal field sets are dropped and counted.
    wa.delete();
    wd.delete();
    err_seen = 0;
    start_session(10'h300);
    send(2'b11, 6'd0, 5'd0, 5'd0, 14'd0, 30'd0, 1'b0);
    #1;
    check("t4_err1",   {31'd0, err_illegal}, 32'd1);
    check("t4_we1",    {31'd0, imem_we},     32'd0);
    send(2'b00, 6'b001110, 5'd1, 5'd1, 14'd1, 30'd0, 1'b0);
    #1;
    check("t4_err2",   {31'd0, err_illegal}, 32'd1);
    check("t4_we2",    {31'd0, imem_we},     32'd0);
    send_idx(0, 1'b1);
    wait_done("t4_done");
    check("t4_err_count", {24'd0, err_count}, 32'd2);
    check("t4_err_pulses", err_seen, 32'd2);
    check("t4_nwrites", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      check("t4_addr",  {22'd0, wa[0]}, 32'h300);
      check("t4_data",  wd[0], 32'h0419_0010);
    end

    // Address wrap-around at the top of the space.
    wa.delete();
    wd.delete();
    start_session(10'h3FC);
    send_idx(3, 1'b0);
    send_idx(4, 1'b1);
    wait_done("t5_done");
    check("t5_nwrites", wa.size(), 32'd2);
    if (wa.size() > 1) begin
      check("t5_addr0", {22'd0, wa[0]}, 32'h3FC);
      check("t5_data0", wd[0], 32'h1A00_0000);
      check("t5_addr1", {22'd0, wa[1]}, 32'h000);
      check("t5_data1", wd[1], 32'h4108_4001);
    end

    // Reset in DRAIN with three words queued (start held alongside reset).
    imem_ready = 1'b0;
    start_session(10'h100);
    send_idx(0, 1'b0);
    send_idx(1, 1'b0);
    send_idx(2, 1'b1);
    #1;
    check("t6_busy_drain", {31'd0, busy},    32'd1);
    check("t6_we_held",    {31'd0, imem_we}, 32'd0);
    reset = 1'b1;
    start = 1'b1;
    step();
    #1;
    check("t6_busy",      {31'd0, busy},       32'd0);
    check("t6_we",        {31'd0, imem_we},    32'd0);
    check("t6_in_ready",  {31'd0, in_ready},   32'd0);
    check("t6_err_count", {24'd0, err_count},  32'd0);
    check("t6_done",      {31'd0, done},       32'd0);
    reset      = 1'b0;
    start      = 1'b0;
    imem_ready = 1'b1;
    wa.delete();
    wd.delete();
    done_seen = 0;
    repeat (4) step();
    #1;
    check("t6_no_writes", wa.size(),    32'd0);
    check("t6_no_done",   done_seen,    32'd0);
    check("t6_idle",      {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
